// File: rtl/osd_text_writer.sv
// Byte-stream text writer for CHR_GEN: keeps a text cursor, interprets CR/LF/BS/FF
// and turns printable bytes and screen clears into single-period VRAM write cycles.
module osd_text_writer #(
  parameter int          C_COLS_W     = 5,
  parameter int          C_ROWS       = 24,
  parameter logic [7:0]  C_BLANK_CHR  = 8'h20,
  parameter bit          C_CLR_ON_RST = 1'b1
) (
  input  logic                CK_i,
  input  logic                XSR_i,
  input  logic                CK_EE_i,
  input  logic [7:0]          DATs_i,
  input  logic                DAT_VALID_i,
  output logic                DAT_READY_o,
  output logic [7:0]          VRAM_WDs_o,
  output logic [9:0]          VRAM_WAs_o,
  output logic                VRAM_WE_o,
  output logic                BUSY_o,
  output logic [C_COLS_W-1:0] CUR_COLs_o,
  output logic [4:0]          CUR_ROWs_o
);

  localparam int                  C_CELLS   = C_ROWS * (1 << C_COLS_W);
  localparam logic [9:0]          C_LAST    = 10'(C_CELLS - 1);
  localparam logic [C_COLS_W-1:0] C_COL_MAX = {C_COLS_W{1'b1}};
  localparam logic [C_COLS_W-1:0] C_COL_ONE = {{(C_COLS_W-1){1'b0}}, 1'b1};
  localparam logic [4:0]          C_ROW_MAX = 5'(C_ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_CLR  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [C_COLS_W-1:0] col_q, col_d;
  logic [4:0]          row_q, row_d;
  logic [9:0]          addr_q, addr_d;
  logic [7:0]          wd_q, wd_d;
  logic [9:0]          wa_q, wa_d;
  logic                we_q, we_d;

  function automatic logic [9:0] cell_addr(input logic [4:0] row, input logic [C_COLS_W-1:0] col);
    return (10'(row) << C_COLS_W) | 10'(col);
  endfunction

  function automatic logic [4:0] row_next(input logic [4:0] row);
    return (row == C_ROW_MAX) ? 5'd0 : row + 5'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    wa_d    = wa_q;
    we_d    = we_q;
    if (CK_EE_i) begin
      case (state_q)
        S_IDLE: begin
          we_d = 1'b0;
          if (DAT_VALID_i) begin
            if (DATs_i >= 8'h20) begin
              wd_d    = DATs_i;
              wa_d    = cell_addr(row_q, col_q);
              we_d    = 1'b1;
              state_d = S_WR;
              if (col_q == C_COL_MAX) begin
                col_d = '0;
                row_d = row_next(row_q);
              end else begin
                col_d = col_q + C_COL_ONE;
              end
            end else begin
              case (DATs_i)
                8'h0D: col_d = '0;
                8'h0A: row_d = row_next(row_q);
                8'h08: begin
                  // BS at column 0 is a no-op: no wrap back to the previous row
                  if (col_q != '0) begin
                    col_d   = col_q - C_COL_ONE;
                    wd_d    = C_BLANK_CHR;
                    wa_d    = cell_addr(row_q, col_q - C_COL_ONE);
                    we_d    = 1'b1;
                    state_d = S_WR;
                  end else begin
                    col_d = col_q;
                  end
                end
                8'h0C: begin
                  addr_d  = 10'd0;
                  wd_d    = C_BLANK_CHR;
                  wa_d    = 10'd0;
                  we_d    = 1'b1;
                  state_d = S_CLR;
                end
                default: state_d = S_IDLE;
              endcase
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WR: begin
          we_d    = 1'b0;
          state_d = S_IDLE;
        end
        S_CLR: begin
          // WE still low means the sweep was entered from reset: cell 0 not yet written
          if (!we_q) begin
            addr_d = 10'd0;
            wd_d   = C_BLANK_CHR;
            wa_d   = 10'd0;
            we_d   = 1'b1;
          end else if (addr_q == C_LAST) begin
            we_d    = 1'b0;
            col_d   = '0;
            row_d   = 5'd0;
            state_d = S_IDLE;
          end else begin
            addr_d = addr_q + 10'd1;
            wd_d   = C_BLANK_CHR;
            wa_d   = addr_q + 10'd1;
            we_d   = 1'b1;
          end
        end
        default: begin
          we_d    = 1'b0;
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge CK_i) begin
    if (!XSR_i) begin
      state_q <= C_CLR_ON_RST ? S_CLR : S_IDLE;
      col_q   <= '0;
      row_q   <= 5'd0;
      addr_q  <= 10'd0;
      wd_q    <= 8'd0;
      wa_q    <= 10'd0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      wa_q    <= wa_d;
      we_q    <= we_d;
    end
  end

  assign DAT_READY_o = XSR_i & (state_q == S_IDLE);
  assign BUSY_o      = (state_q != S_IDLE);
  assign VRAM_WDs_o  = wd_q;
  assign VRAM_WAs_o  = wa_q;
  assign VRAM_WE_o   = we_q;
  assign CUR_COLs_o  = col_q;
  assign CUR_ROWs_o  = row_q;

endmodule

// File: tb/tb_osd_text_writer.sv
// Directed bench for osd_text_writer: reset clear, text, wrap, control codes,
// FF with a held byte, and reset in the middle of a clear sweep.
module tb_osd_text_writer;

  logic       clk = 1'b0;
  logic       xsr = 1'b0;
  logic       ck_ee = 1'b0;
  logic [7:0] dat = 8'h00;
  logic       valid = 1'b0;
  logic       ready;
  logic [7:0] wd;
  logic [9:0] wa;
  logic       we;
  logic       busy;
  logic [4:0] col;
  logic [4:0] row;
  int         cmp = 0;
  int         mis = 0;

  osd_text_writer dut (
    .CK_i(clk), .XSR_i(xsr), .CK_EE_i(ck_ee), .DATs_i(dat), .DAT_VALID_i(valid),
    .DAT_READY_o(ready), .VRAM_WDs_o(wd), .VRAM_WAs_o(wa), .VRAM_WE_o(we),
    .BUSY_o(busy), .CUR_COLs_o(col), .CUR_ROWs_o(row)
  );

  always #5 clk = ~clk;

  // enable is high for one clock in every eight
  initial begin
    logic [2:0] div;
    div = 3'd0;
    forever begin
      @(negedge clk);
      div = div + 3'd1;
      ck_ee = (div == 3'd7);
    end
  end

  task automatic step_ee();
    int n;
    n = 0;
    @(posedge clk);
    while (!ck_ee && n < 32) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 32) begin
      cmp++; mis++;
      $display("FAIL step_ee: no enable within 32 clocks");
    end
  endtask

  task automatic put(input logic [7:0] b);
    dat = b;
    valid = 1'b1;
    step_ee();
    valid = 1'b0;
  endtask

  task automatic type_chr(input logic [7:0] b);
    put(b);
    step_ee();
  endtask

  task automatic test_reset();
    xsr = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    cmp++;
    if ({we, wa, wd, col, row, ready} !== 29'd0) begin
      mis++;
      $display("FAIL reset_outputs: got we=%b wa=%0d wd=%h col=%0d row=%0d rdy=%b, want all 0",
               we, wa, wd, col, row, ready);
    end
    cmp++;
    if (busy !== 1'b1) begin
      mis++;
      $display("FAIL reset_busy: got %b want 1", busy);
    end
  endtask

  task automatic test_clear_on_reset();
    int bad;
    bad = 0;
    xsr = 1'b1;
    for (int i = 0; i < 768; i++) begin
      step_ee();
      cmp++;
      if ({we, wa, wd} !== {1'b1, 10'(i), 8'h20}) begin
        mis++; bad++;
        if (bad < 5) $display("FAIL clr_sweep[%0d]: got we=%b wa=%0d wd=%h want 1/%0d/20", i, we, wa, wd, i);
      end
    end
    step_ee();
    cmp++;
    if ({we, ready, busy, col, row} !== {1'b0, 1'b1, 1'b0, 5'd0, 5'd0}) begin
      mis++;
      $display("FAIL clr_done: got we=%b rdy=%b busy=%b cur=(%0d,%0d) want 0/1/0 (0,0)",
               we, ready, busy, row, col);
    end
  endtask

  task automatic test_text();
    put(8'h41);
    cmp++;
    if ({we, wa, wd, col} !== {1'b1, 10'd0, 8'h41, 5'd1}) begin
      mis++;
      $display("FAIL text_A: got we=%b wa=%0d wd=%h col=%0d want 1/0/41/1", we, wa, wd, col);
    end
    repeat (3) @(posedge clk);
    #1;
    cmp++;
    if ({we, ready} !== 2'b10) begin
      mis++;
      $display("FAIL text_hold: got we=%b rdy=%b want 1/0", we, ready);
    end
    step_ee();
    cmp++;
    if (we !== 1'b0) begin
      mis++;
      $display("FAIL text_gap: got we=%b want 0", we);
    end
    put(8'h42);
    cmp++;
    if ({we, wa, wd} !== {1'b1, 10'd1, 8'h42}) begin
      mis++;
      $display("FAIL text_B: got we=%b wa=%0d wd=%h want 1/1/42", we, wa, wd);
    end
    step_ee();
    cmp++;
    if ({we, col, row} !== {1'b0, 5'd2, 5'd0}) begin
      mis++;
      $display("FAIL text_cursor: got we=%b col=%0d row=%0d want 0/2/0", we, col, row);
    end
  endtask

  task automatic test_wrap();
    put(8'h0D);
    for (int i = 0; i < 23; i++) put(8'h0A);
    cmp++;
    if ({we, col, row} !== {1'b0, 5'd0, 5'd23}) begin
      mis++;
      $display("FAIL wrap_setup: got we=%b col=%0d row=%0d want 0/0/23", we, col, row);
    end
    for (int i = 0; i < 32; i++) begin
      put(8'h61 + 8'(i % 26));
      if (i == 31) begin
        cmp++;
        if ({we, wa, wd} !== {1'b1, 10'd767, 8'h66}) begin
          mis++;
          $display("FAIL wrap_last: got we=%b wa=%0d wd=%h want 1/767/66", we, wa, wd);
        end
      end
      step_ee();
    end
    cmp++;
    if ({col, row} !== {5'd0, 5'd0}) begin
      mis++;
      $display("FAIL wrap_cursor: got (%0d,%0d) want (0,0)", row, col);
    end
    for (int i = 0; i < 23; i++) put(8'h0A);
    put(8'h0A);
    cmp++;
    if ({we, row} !== {1'b0, 5'd0}) begin
      mis++;
      $display("FAIL lf_wrap: got we=%b row=%0d want 0/0", we, row);
    end
  endtask

  task automatic test_backspace();
    put(8'h08);
    cmp++;
    if ({we, col, row, ready} !== {1'b0, 5'd0, 5'd0, 1'b1}) begin
      mis++;
      $display("FAIL bs_col0: got we=%b col=%0d row=%0d rdy=%b want 0/0/0/1", we, col, row, ready);
    end
    put(8'h01);
    cmp++;
    if ({we, col, row} !== {1'b0, 5'd0, 5'd0}) begin
      mis++;
      $display("FAIL ctl_other: got we=%b col=%0d row=%0d want 0/0/0", we, col, row);
    end
    for (int i = 0; i < 5; i++) type_chr(8'h31 + 8'(i));
    put(8'h08);
    cmp++;
    if ({we, wa, wd, col} !== {1'b1, 10'd4, 8'h20, 5'd4}) begin
      mis++;
      $display("FAIL bs_col5: got we=%b wa=%0d wd=%h col=%0d want 1/4/20/4", we, wa, wd, col);
    end
    step_ee();
  endtask

  task automatic test_ff_held();
    int bad;
    bad = 0;
    put(8'h0D);
    for (int i = 0; i < 3; i++) put(8'h0A);
    for (int i = 0; i < 7; i++) type_chr(8'h78);
    cmp++;
    if ({col, row} !== {5'd7, 5'd3}) begin
      mis++;
      $display("FAIL ff_setup: got (%0d,%0d) want (3,7)", row, col);
    end
    dat = 8'h0C;
    valid = 1'b1;
    step_ee();
    dat = 8'h5A;
    cmp++;
    if ({we, wa, wd, ready, busy} !== {1'b1, 10'd0, 8'h20, 1'b0, 1'b1}) begin
      mis++;
      $display("FAIL ff_start: got we=%b wa=%0d wd=%h rdy=%b busy=%b want 1/0/20/0/1", we, wa, wd, ready, busy);
    end
    for (int i = 1; i < 768; i++) begin
      step_ee();
      cmp++;
      if ({we, wa, wd, ready} !== {1'b1, 10'(i), 8'h20, 1'b0}) begin
        mis++; bad++;
        if (bad < 5) $display("FAIL ff_sweep[%0d]: got we=%b wa=%0d wd=%h rdy=%b want 1/%0d/20/0", i, we, wa, wd, ready, i);
      end
    end
    step_ee();
    cmp++;
    if ({we, ready, col, row} !== {1'b0, 1'b1, 5'd0, 5'd0}) begin
      mis++;
      $display("FAIL ff_done: got we=%b rdy=%b cur=(%0d,%0d) want 0/1 (0,0)", we, ready, row, col);
    end
    step_ee();
    valid = 1'b0;
    cmp++;
    if ({we, wa, wd, col} !== {1'b1, 10'd0, 8'h5A, 5'd1}) begin
      mis++;
      $display("FAIL ff_held_byte: got we=%b wa=%0d wd=%h col=%0d want 1/0/5a/1", we, wa, wd, col);
    end
    step_ee();
  endtask

  task automatic test_reset_mid_clear();
    int bad;
    bad = 0;
    put(8'h0C);
    for (int i = 0; i < 100; i++) step_ee();
    cmp++;
    if ({we, wa} !== {1'b1, 10'd100}) begin
      mis++;
      $display("FAIL rst_mid_setup: got we=%b wa=%0d want 1/100", we, wa);
    end
    xsr = 1'b0;
    @(posedge clk);
    #1;
    xsr = 1'b1;
    cmp++;
    if ({we, wa, col, row} !== {1'b0, 10'd0, 5'd0, 5'd0}) begin
      mis++;
      $display("FAIL rst_mid_we: got we=%b wa=%0d cur=(%0d,%0d) want 0/0 (0,0)", we, wa, row, col);
    end
    for (int i = 0; i < 768; i++) begin
      step_ee();
      cmp++;
      if ({we, wa, wd} !== {1'b1, 10'(i), 8'h20}) begin
        mis++; bad++;
        if (bad < 5) $display("FAIL rst_mid_sweep[%0d]: got we=%b wa=%0d wd=%h want 1/%0d/20", i, we, wa, wd, i);
      end
    end
    step_ee();
    cmp++;
    if ({we, ready} !== 2'b01) begin
      mis++;
      $display("FAIL rst_mid_done: got we=%b rdy=%b want 0/1", we, ready);
    end
  endtask

  initial begin
    test_reset();
    test_clear_on_reset();
    test_text();
    test_wrap();
    test_backspace();
    test_ff_held();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule
